rv_decode_stage: RTL and testbench
==================================

Name: rv_decode_stage

Overview:
- Registered, parametrised RV32I/RV64I decode stage. It sits between instruction fetch and execute.
- Accepts one instruction with its PC over a valid/ready handshake and decodes every base-ISA integer class, not just OP/OP-IMM.
- Produces format-correct XLEN-wide immediates, the full ALU op set (including shifts) and an illegal flag.
- Holds the result in an output register with backpressure, a flush input and a saturating illegal-instruction counter.

Parameters:
- XLEN, 32, datapath width: 32 or 64 only; sets immediate width, PC width and shamt width (5 or 6 bits).
- CNT_W, 16, width of illegal_count.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  discards the held instruction and blocks acceptance this cycle.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_instruction  in  32  raw instruction.
- in_pc  in  XLEN  PC of the instruction.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute consumes the bundle.
- out_pc  out  XLEN  registered PC.
- out_rd, out_rs1, out_rs2  out  5 each  register fields.
- out_funct3  out  3  funct3 field.
- out_imm  out  XLEN  sign-extended immediate, selected by format.
- out_alu_op  out  4  ALU operation.
- out_class  out  4  instruction class.
- out_uses_imm  out  1  ALU operand B is out_imm.
- out_writes_rd  out  1  writes rd, and rd != 0.
- out_illegal  out  1  unsupported or malformed encoding.
- illegal_count  out  CNT_W  saturating count of accepted illegal instructions.

Behaviour:
- Reset (async, active-high): every output register goes to 0, including out_valid and illegal_count. in_ready is 1 after reset.
- Combinational signals:
  - accept = in_valid & in_ready.
  - in_ready = !flush & (!out_valid | out_ready).
- Latency and throughput: one cycle. Full throughput when out_ready is held at 1.
- Registered updates:
  - On accept: all out_* fields load the decode of in_instruction/in_pc and out_valid <= 1.
  - Else if out_valid & out_ready: out_valid <= 0.
  - Else: hold. Fields must stay stable while out_valid & !out_ready.
  - flush: out_valid <= 0 and no accept that cycle. Flush takes priority over a simultaneous out_ready.
- Opcodes and classes (out_class): OP 0x33=0, OP_IMM 0x13=1, LOAD 0x03=2, STORE 0x23=3, BRANCH 0x63=4, JAL 0x6F=5, JALR 0x67=6, LUI 0x37=7, AUIPC 0x17=8. Any other opcode is class 15 with out_illegal=1.
- Immediates (sign bit is inst[31], extended to XLEN):
  - I-type: OP_IMM, LOAD, JALR.
  - S-type: STORE.
  - B-type: BRANCH, bit0=0.
  - J-type: JAL, bit0=0.
  - U-type: LUI, AUIPC = inst[31:12]<<12, sign-extended for XLEN=64.
  - OP: out_imm=0.
- ALU op, OP/OP_IMM by funct3 and funct7:
  - 0: ADD; SUB only for OP with funct7=0x20.
  - 1: SLL. 2: LT. 3: LTU. 4: XOR.
  - 5: SRL with funct7=0, SRA with funct7=0x20.
  - 6: OR. 7: AND.
- ALU op, other classes:
  - LOAD, STORE, JALR, AUIPC, JAL: ADD.
  - BRANCH: SUB for funct3 0/1, LT for 4/5, LTU for 6/7.
  - LUI: PASSB.
- Illegal conditions (out_illegal=1, alu_op=ZERO, writes_rd=0):
  - OP with funct7 not equal to 0, or 0x20 where 0x20 is disallowed.
  - OP_IMM shift with upper bits non-zero: bits [31:25] for XLEN=32, [31:26] for XLEN=64; bit 30 is allowed only for SRAI.
  - BRANCH funct3 2 or 3.
  - JALR funct3 != 0.
  - LOAD funct3 of 3 (XLEN=32 only), 6 (XLEN=32 only) or 7.
  - STORE funct3 > 2 (XLEN=32) or > 3 (XLEN=64).
  - inst[1:0] != 2'b11.
- out_uses_imm = 1 for all classes except OP and BRANCH.
- out_writes_rd = 0 for STORE and BRANCH.
- illegal_count: increments on accept of an illegal instruction and saturates at all-ones. A flushed bundle is already counted.

Decomposition:
- Package rv_decode_pkg holds:
  - Opcode constants.
  - funct3/funct7 constants.
  - Class encodings.
  - ALU op encodings: ZERO=0, ADD=1, SUB=2, LT=3, LTU=4, AND=5, OR=6, XOR=7, SLL=8, SRL=9, SRA=10, PASSB=11. These are shared with the ALU.
- Sub-module rv_decode_comb holds the pure combinational decode, parametrised by XLEN. The top module holds the handshake register and the counter.

Test Plan:
- Reset, then 0xFFB10093 (addi x1,x2,-5) with out_ready=1 -> next cycle out_valid=1, rd=1, rs1=2, imm=0xFFFFFFFB, alu_op=ADD, class=1, uses_imm=1.
- 0x405201B3 (sub x3,x4,x5) -> alu_op=SUB, rd=3, rs1=4, rs2=5, uses_imm=0. 0x123453B7 (lui x7) -> imm=0x12345000, alu_op=PASSB. 0x008000EF (jal x1,+8) -> imm=8, class=5.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable. Release -> one transfer per cycle, with no loss or duplication over 8 back-to-back instructions.
- 0x00000000 and 0x02001013 (slli with bad funct7) -> out_illegal=1, illegal_count=2. With CNT_W=2 and 5 illegal instructions -> count saturates at 3.
- flush while out_valid=1 and in_valid=1 -> next cycle out_valid=0 and the input is not accepted. Assert reset mid-stream -> outputs 0 immediately (async).
- XLEN=64: 0x03F0D093 (srli x1,x1,63) is legal, alu_op=SRL. 0x8000006F -> imm=0xFFFFFFFFFFF00000.

Source files
------------

// File: rtl/rv_decode_pkg.sv
// Shared RV32I/RV64I decode constants, class and ALU-op encodings.
// The ALU op encodings are shared with the execute-stage ALU; keep them in step.
package rv_decode_pkg;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;

  localparam logic [2:0] F3_ADD_SUB = 3'd0;
  localparam logic [2:0] F3_SLL     = 3'd1;
  localparam logic [2:0] F3_SLT     = 3'd2;
  localparam logic [2:0] F3_SLTU    = 3'd3;
  localparam logic [2:0] F3_XOR     = 3'd4;
  localparam logic [2:0] F3_SRL_SRA = 3'd5;
  localparam logic [2:0] F3_OR      = 3'd6;
  localparam logic [2:0] F3_AND     = 3'd7;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [3:0] {
    CLS_OP      = 4'd0,
    CLS_OP_IMM  = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_JAL     = 4'd5,
    CLS_JALR    = 4'd6,
    CLS_LUI     = 4'd7,
    CLS_AUIPC   = 4'd8,
    CLS_ILLEGAL = 4'd15
  } cls_e;

  typedef enum logic [3:0] {
    ALU_ZERO  = 4'd0,
    ALU_ADD   = 4'd1,
    ALU_SUB   = 4'd2,
    ALU_LT    = 4'd3,
    ALU_LTU   = 4'd4,
    ALU_AND   = 4'd5,
    ALU_OR    = 4'd6,
    ALU_XOR   = 4'd7,
    ALU_SLL   = 4'd8,
    ALU_SRL   = 4'd9,
    ALU_SRA   = 4'd10,
    ALU_PASSB = 4'd11
  } alu_op_e;

  // XLEN-independent part of the decoded bundle; immediate and PC travel alongside.
  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    alu_op_e    alu_op;
    cls_e       cls;
    logic       uses_imm;
    logic       writes_rd;
    logic       illegal;
  } dec_t;

  function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_LT;
      F3_SLTU:    op = ALU_LTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv_decode_comb.sv
// Pure combinational RV32I/RV64I decode of one instruction word.
// Zero latency, no flow control; the stage register lives in the top.
module rv_decode_comb
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output dec_t            dec,
  output logic [XLEN-1:0] imm
);

  localparam logic [2:0] STORE_F3_MAX = (XLEN == 32) ? 3'd2 : 3'd3;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [6:0] shift_hi;
  logic       illegal;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];
  // Bits above shamt; inst[25] is shamt[5] on RV64 so it is only checked on RV32.
  assign shift_hi = {inst[31:26], (XLEN == 32) ? inst[25] : 1'b0};

  always_comb begin
    dec          = '0;
    dec.rd       = inst[11:7];
    dec.rs1      = inst[19:15];
    dec.rs2      = inst[24:20];
    dec.funct3   = f3;
    dec.cls      = CLS_ILLEGAL;
    dec.alu_op   = ALU_ZERO;
    dec.uses_imm = 1'b1;
    imm          = '0;
    illegal      = 1'b0;

    case (opcode)
      OPC_OP: begin
        dec.cls      = CLS_OP;
        dec.uses_imm = 1'b0;
        dec.alu_op   = alu_from_funct3(f3, f7 == F7_ALT);
        if (!(f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD_SUB || f3 == F3_SRL_SRA))))
          illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.cls = CLS_OP_IMM;
        imm     = XLEN'($signed(inst[31:20]));
        if (f3 == F3_SLL) begin
          dec.alu_op = ALU_SLL;
          if (shift_hi != 7'd0) illegal = 1'b1;
        end else if (f3 == F3_SRL_SRA) begin
          dec.alu_op = inst[30] ? ALU_SRA : ALU_SRL;
          if ((shift_hi & 7'b1011111) != 7'd0) illegal = 1'b1;
        end else begin
          dec.alu_op = alu_from_funct3(f3, 1'b0);
        end
      end
      OPC_LOAD: begin
        dec.cls    = CLS_LOAD;
        dec.alu_op = ALU_ADD;
        imm        = XLEN'($signed(inst[31:20]));
        if (f3 == 3'd7 || (XLEN == 32 && (f3 == 3'd3 || f3 == 3'd6)))
          illegal = 1'b1;
      end
      OPC_STORE: begin
        dec.cls    = CLS_STORE;
        dec.alu_op = ALU_ADD;
        imm        = XLEN'($signed({inst[31:25], inst[11:7]}));
        if (f3 > STORE_F3_MAX) illegal = 1'b1;
      end
      OPC_BRANCH: begin
        dec.cls      = CLS_BRANCH;
        dec.uses_imm = 1'b0;
        imm          = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
        case (f3[2:1])
          2'b00:   dec.alu_op = ALU_SUB;
          2'b10:   dec.alu_op = ALU_LT;
          2'b11:   dec.alu_op = ALU_LTU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_JAL: begin
        dec.cls    = CLS_JAL;
        dec.alu_op = ALU_ADD;
        imm        = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      end
      OPC_JALR: begin
        dec.cls    = CLS_JALR;
        dec.alu_op = ALU_ADD;
        imm        = XLEN'($signed(inst[31:20]));
        if (f3 != 3'd0) illegal = 1'b1;
      end
      OPC_LUI: begin
        dec.cls    = CLS_LUI;
        dec.alu_op = ALU_PASSB;
        imm        = XLEN'($signed({inst[31:12], 12'h000}));
      end
      OPC_AUIPC: begin
        dec.cls    = CLS_AUIPC;
        dec.alu_op = ALU_ADD;
        imm        = XLEN'($signed({inst[31:12], 12'h000}));
      end
      default: illegal = 1'b1;
    endcase

    if (inst[1:0] != 2'b11) illegal = 1'b1;

    dec.illegal   = illegal;
    dec.writes_rd = !illegal && dec.cls != CLS_STORE && dec.cls != CLS_BRANCH
                    && dec.rd != 5'd0;
    if (illegal) dec.alu_op = ALU_ZERO;
  end

endmodule

// File: rtl/rv_decode_stage.sv
// Registered decode stage between fetch and execute; one-cycle latency, full throughput.
// Output register holds while out_valid & !out_ready; flush drops the held bundle and blocks input.
module rv_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instruction,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_funct3,
  output logic [XLEN-1:0]  out_imm,
  output logic [3:0]       out_alu_op,
  output logic [3:0]       out_class,
  output logic             out_uses_imm,
  output logic             out_writes_rd,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  dec_t            dec_c;
  logic [XLEN-1:0] imm_c;
  logic            accept;

  dec_t            dec_d,   dec_q;
  logic [XLEN-1:0] imm_d,   imm_q;
  logic [XLEN-1:0] pc_d,    pc_q;
  logic            valid_d, valid_q;
  logic [CNT_W-1:0] cnt_d,  cnt_q;

  rv_decode_comb #(.XLEN(XLEN)) u_comb (
    .inst (in_instruction),
    .dec  (dec_c),
    .imm  (imm_c)
  );

  assign in_ready = !flush && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    dec_d   = dec_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (accept) begin
      dec_d   = dec_c;
      imm_d   = imm_c;
      pc_d    = in_pc;
      valid_d = 1'b1;
      // Counted at acceptance, so a later flush of this bundle does not undo it.
      if (dec_c.illegal && cnt_q != {CNT_W{1'b1}})
        cnt_d = cnt_q + CNT_W'(1);
    end else if (flush) begin
      valid_d = 1'b0;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dec_q   <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      dec_q   <= dec_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_pc        = pc_q;
  assign out_imm       = imm_q;
  assign out_rd        = dec_q.rd;
  assign out_rs1       = dec_q.rs1;
  assign out_rs2       = dec_q.rs2;
  assign out_funct3    = dec_q.funct3;
  assign out_alu_op    = dec_q.alu_op;
  assign out_class     = dec_q.cls;
  assign out_uses_imm  = dec_q.uses_imm;
  assign out_writes_rd = dec_q.writes_rd;
  assign out_illegal   = dec_q.illegal;
  assign illegal_count = cnt_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: a 32-bit instance, a 32-bit instance with a
// 2-bit illegal counter and a 64-bit instance all see the same input stream.
module tb_rv_decode_stage;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instruction;
  logic [63:0] in_pc64;
  logic [31:0] in_pc32;
  assign in_pc32 = in_pc64[31:0];

  logic        in_ready, out_valid, out_uses_imm, out_writes_rd, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3;
  logic [3:0]  out_alu_op, out_class;
  logic [15:0] illegal_count;

  logic        c2_in_ready, c2_out_valid, c2_out_uses_imm, c2_out_writes_rd, c2_out_illegal;
  logic [31:0] c2_out_pc, c2_out_imm;
  logic [4:0]  c2_out_rd, c2_out_rs1, c2_out_rs2;
  logic [2:0]  c2_out_funct3;
  logic [3:0]  c2_out_alu_op, c2_out_class;
  logic [1:0]  c2_illegal_count;

  logic        w_in_ready, w_out_valid, w_out_uses_imm, w_out_writes_rd, w_out_illegal;
  logic [63:0] w_out_pc, w_out_imm;
  logic [4:0]  w_out_rd, w_out_rs1, w_out_rs2;
  logic [2:0]  w_out_funct3;
  logic [3:0]  w_out_alu_op, w_out_class;
  logic [15:0] w_illegal_count;

  rv_decode_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instruction(in_instruction), .in_pc(in_pc32),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3),
    .out_imm(out_imm), .out_alu_op(out_alu_op), .out_class(out_class),
    .out_uses_imm(out_uses_imm), .out_writes_rd(out_writes_rd), .out_illegal(out_illegal),
    .illegal_count(illegal_count)
  );

  rv_decode_stage #(.XLEN(32), .CNT_W(2)) dut_c2 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(c2_in_ready), .in_instruction(in_instruction), .in_pc(in_pc32),
    .out_valid(c2_out_valid), .out_ready(out_ready), .out_pc(c2_out_pc),
    .out_rd(c2_out_rd), .out_rs1(c2_out_rs1), .out_rs2(c2_out_rs2), .out_funct3(c2_out_funct3),
    .out_imm(c2_out_imm), .out_alu_op(c2_out_alu_op), .out_class(c2_out_class),
    .out_uses_imm(c2_out_uses_imm), .out_writes_rd(c2_out_writes_rd), .out_illegal(c2_out_illegal),
    .illegal_count(c2_illegal_count)
  );

  rv_decode_stage #(.XLEN(64), .CNT_W(16)) dut_w (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(w_in_ready), .in_instruction(in_instruction), .in_pc(in_pc64),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_pc(w_out_pc),
    .out_rd(w_out_rd), .out_rs1(w_out_rs1), .out_rs2(w_out_rs2), .out_funct3(w_out_funct3),
    .out_imm(w_out_imm), .out_alu_op(w_out_alu_op), .out_class(w_out_class),
    .out_uses_imm(w_out_uses_imm), .out_writes_rd(w_out_writes_rd), .out_illegal(w_out_illegal),
    .illegal_count(w_illegal_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one instruction for one edge (assumes in_ready), then sample at edge+1.
  task automatic send(input logic [31:0] ins, input logic [63:0] pc);
    in_valid       = 1'b1;
    in_instruction = ins;
    in_pc64        = pc;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] mk_addi(input int k);
    return 32'((k << 20) | (k << 7) | 32'h13);
  endfunction

  initial begin
    int prod;
    int cons;
    reset          = 1'b1;
    flush          = 1'b0;
    in_valid       = 1'b0;
    in_instruction = '0;
    in_pc64        = '0;
    out_ready      = 1'b1;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_count", illegal_count, 0);
    chk("rst_imm", out_imm, 0);
    chk("rst_pc", w_out_pc, 0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // addi x1,x2,-5
    send(32'hFFB10093, 64'h100);
    chk("addi_valid", out_valid, 1);
    chk("addi_rd", out_rd, 1);
    chk("addi_rs1", out_rs1, 2);
    chk("addi_imm", out_imm, 32'hFFFFFFFB);
    chk("addi_alu", out_alu_op, 1);
    chk("addi_class", out_class, 1);
    chk("addi_uses_imm", out_uses_imm, 1);
    chk("addi_writes_rd", out_writes_rd, 1);
    chk("addi_pc", out_pc, 32'h100);
    chk("addi_imm64", w_out_imm, 64'hFFFFFFFFFFFFFFFB);

    // sub x3,x4,x5
    send(32'h405201B3, 64'h104);
    chk("sub_alu", out_alu_op, 2);
    chk("sub_rd", out_rd, 3);
    chk("sub_rs1", out_rs1, 4);
    chk("sub_rs2", out_rs2, 5);
    chk("sub_uses_imm", out_uses_imm, 0);
    chk("sub_imm", out_imm, 0);
    chk("sub_class", out_class, 0);

    // lui x7,0x12345
    send(32'h123453B7, 64'h108);
    chk("lui_imm", out_imm, 32'h12345000);
    chk("lui_alu", out_alu_op, 11);
    chk("lui_class", out_class, 7);

    // jal x1,+8
    send(32'h008000EF, 64'h10C);
    chk("jal_imm", out_imm, 8);
    chk("jal_class", out_class, 5);
    chk("jal_alu", out_alu_op, 1);

    // sw x1,8(x2)
    send(32'h00112423, 64'h110);
    chk("sw_imm", out_imm, 8);
    chk("sw_class", out_class, 3);
    chk("sw_writes_rd", out_writes_rd, 0);
    chk("sw_funct3", out_funct3, 2);

    // beq x0,x0,-4
    send(32'hFE000EE3, 64'h114);
    chk("beq_imm", out_imm, 32'hFFFFFFFC);
    chk("beq_class", out_class, 4);
    chk("beq_alu", out_alu_op, 2);
    chk("beq_uses_imm", out_uses_imm, 0);
    chk("beq_writes_rd", out_writes_rd, 0);

    // srai x1,x1,3
    send(32'h4030D093, 64'h118);
    chk("srai_alu", out_alu_op, 10);
    chk("srai_illegal", out_illegal, 0);
    chk("srai_imm", out_imm, 32'h403);
    chk("srai_alu64", w_out_alu_op, 10);
    chk("legal_count", illegal_count, 0);

    // Consumer drains the held bundle with no new input.
    @(posedge clock);
    #1;
    chk("drain_valid", out_valid, 0);

    // Backpressure: hold item 1 for three cycles while item 2 waits.
    send(mk_addi(1), 64'h200);
    chk("bp_first_imm", out_imm, 1);
    out_ready      = 1'b0;
    in_valid       = 1'b1;
    in_instruction = mk_addi(2);
    #1;
    chk("bp_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_imm", out_imm, 1);
      chk("bp_hold_rd", out_rd, 1);
    end

    // Release and stream items 2..8, with one consumer stall along the way.
    prod = 2;
    cons = 1;
    for (int cyc = 0; cyc < 40 && cons <= 8; cyc++) begin
      in_valid       = (prod <= 8);
      in_instruction = mk_addi(prod);
      out_ready      = (cyc != 3);
      #3;
      if (out_valid && out_ready) begin
        chk("stream_imm", out_imm, 64'(cons));
        cons++;
      end
      if (in_valid && in_ready) prod++;
      @(posedge clock);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_done", 64'(cons), 9);

    // Illegal encodings (RV32 view).
    send(32'h00000000, 64'h300);
    chk("zero_illegal", out_illegal, 1);
    chk("zero_class", out_class, 15);
    chk("zero_alu", out_alu_op, 0);
    chk("zero_writes_rd", out_writes_rd, 0);
    send(32'h02001013, 64'h304);
    chk("slli_bad_illegal", out_illegal, 1);
    chk("count_two", illegal_count, 2);
    chk("c2_count_two", c2_illegal_count, 2);
    chk("slli_bad_ok64", w_out_illegal, 0);
    send(32'h00002063, 64'h308);
    chk("br_f3_2_illegal", out_illegal, 1);
    send(32'h00001067, 64'h30C);
    chk("jalr_f3_illegal", out_illegal, 1);
    send(32'h00003003, 64'h310);
    chk("ld_illegal32", out_illegal, 1);
    chk("ld_legal64", w_out_illegal, 0);
    chk("ld_alu64", w_out_alu_op, 1);
    send(32'h40001033, 64'h314);
    chk("sll_f7_illegal", out_illegal, 1);
    chk("count_six", illegal_count, 6);
    chk("c2_saturated", c2_illegal_count, 3);
    chk("w_count_four", w_illegal_count, 4);

    // Flush while holding a bundle with a new one offered.
    out_ready      = 1'b0;
    flush          = 1'b1;
    in_valid       = 1'b1;
    in_instruction = 32'h00500293;
    #1;
    chk("flush_in_ready", in_ready, 0);
    @(posedge clock);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_count_kept", illegal_count, 6);
    @(posedge clock);
    #1;
    chk("flush_not_accepted", out_valid, 0);
    out_ready = 1'b1;

    // RV64-specific encodings.
    send(32'h03F0D093, 64'h400);
    chk("srli63_legal64", w_out_illegal, 0);
    chk("srli63_alu64", w_out_alu_op, 9);
    chk("srli63_illegal32", out_illegal, 1);
    chk("count_seven", illegal_count, 7);
    send(32'h8000006F, 64'hFFFF_0000_0000_0500);
    chk("jal_neg_imm64", w_out_imm, 64'hFFFFFFFFFFF00000);
    chk("jal_neg_imm32", out_imm, 32'hFFF00000);
    chk("jal_neg_pc64", w_out_pc, 64'hFFFF_0000_0000_0500);
    send(32'h800000B7, 64'h504);
    chk("lui_neg_imm64", w_out_imm, 64'hFFFFFFFF80000000);
    chk("lui_neg_imm32", out_imm, 32'h80000000);

    // Asynchronous reset mid-stream, between clock edges.
    in_valid       = 1'b1;
    in_instruction = mk_addi(9);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_rd", out_rd, 0);
    chk("arst_imm64", w_out_imm, 0);
    chk("arst_count", illegal_count, 0);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("post_arst_valid", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
